// File: rtl/pcie_link_reset_seq.sv
// rtl/pcie_link_reset_seq.sv - timed PERST#/npor sequencer with LTSSM L0 watch and retry
// Holds the PCIe HIP in reset for a fixed time, then waits for a stable L0 or retries.
module pcie_link_reset_seq #(
  parameter int unsigned PERST_CYCLES        = 100000,
  parameter int unsigned LINK_TIMEOUT_CYCLES = 5000000,
  parameter int unsigned STABLE_CYCLES       = 16,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter logic [4:0]  LTSSM_L0            = 5'h0F,
  parameter int unsigned CNT_W               = 24,
  parameter int unsigned RTY_W               = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hps_reset_n,
  input  logic             sw_reset_req,
  input  logic [4:0]       ltssm_state,
  output logic             perst_n,
  output logic             npor,
  output logic             link_up,
  output logic             link_fail,
  output logic [RTY_W-1:0] retry_count,
  output logic [1:0]       seq_state
);

  localparam logic [1:0] ST_RST_ASSERT = 2'd0;
  localparam logic [1:0] ST_TRAINING   = 2'd1;
  localparam logic [1:0] ST_LINK_UP    = 2'd2;
  localparam logic [1:0] ST_FAILED     = 2'd3;

  localparam int unsigned STB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] PERST_LAST   = CNT_W'(PERST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LINK_TIMEOUT_CYCLES - 1);
  localparam logic [STB_W-1:0] STABLE_LAST  = STB_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RETRY_MAX    = RTY_W'(MAX_RETRIES);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STB_W-1:0] stable_cnt_q, stable_cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             sw_req_prev_q, sw_req_prev_d;
  logic [4:0]       ltssm_meta_q, ltssm_meta_d;
  logic [4:0]       ltssm_s_q, ltssm_s_d;
  logic             perst_n_q, perst_n_d;
  logic             npor_q, npor_d;
  logic             link_up_q, link_up_d;
  logic             link_fail_q, link_fail_d;

  logic req_edge;
  logic ltssm_is_l0;
  logic retry_left;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stable_cnt_d  = stable_cnt_q;
    retry_d       = retry_q;
    sw_req_prev_d = sw_reset_req;
    ltssm_meta_d  = ltssm_state;
    ltssm_s_d     = ltssm_meta_q;

    req_edge    = sw_reset_req & ~sw_req_prev_q;
    ltssm_is_l0 = (ltssm_s_q == LTSSM_L0);
    retry_left  = (retry_q < RETRY_MAX);

    if (!hps_reset_n || req_edge) begin
      state_d      = ST_RST_ASSERT;
      cnt_d        = '0;
      stable_cnt_d = '0;
      retry_d      = '0;
    end else begin
      case (state_q)
        ST_RST_ASSERT: begin
          stable_cnt_d = '0;
          if (cnt_q == PERST_LAST) begin
            state_d = ST_TRAINING;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_TRAINING: begin
          cnt_d        = cnt_q + CNT_W'(1);
          stable_cnt_d = ltssm_is_l0 ? stable_cnt_q + STB_W'(1) : '0;
          // Stability is checked first so it wins over a coincident timeout.
          if (ltssm_is_l0 && (stable_cnt_q == STABLE_LAST)) begin
            state_d      = ST_LINK_UP;
            cnt_d        = '0;
            stable_cnt_d = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d        = '0;
            stable_cnt_d = '0;
            if (retry_left) begin
              retry_d = retry_q + RTY_W'(1);
              state_d = ST_RST_ASSERT;
            end else begin
              state_d = ST_FAILED;
            end
          end
        end
        ST_LINK_UP: begin
          if (!ltssm_is_l0) begin
            cnt_d        = '0;
            stable_cnt_d = '0;
            if (retry_left) begin
              retry_d = retry_q + RTY_W'(1);
              state_d = ST_RST_ASSERT;
            end else begin
              state_d = ST_FAILED;
            end
          end
        end
        default: begin
          state_d = ST_FAILED;
        end
      endcase
    end

    perst_n_d   = (state_d == ST_TRAINING) || (state_d == ST_LINK_UP);
    npor_d      = perst_n_d;
    link_up_d   = (state_d == ST_LINK_UP);
    link_fail_d = (state_d == ST_FAILED);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_RST_ASSERT;
      cnt_q         <= '0;
      stable_cnt_q  <= '0;
      retry_q       <= '0;
      sw_req_prev_q <= 1'b1;
      ltssm_meta_q  <= '0;
      ltssm_s_q     <= '0;
      perst_n_q     <= 1'b0;
      npor_q        <= 1'b0;
      link_up_q     <= 1'b0;
      link_fail_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stable_cnt_q  <= stable_cnt_d;
      retry_q       <= retry_d;
      sw_req_prev_q <= sw_req_prev_d;
      ltssm_meta_q  <= ltssm_meta_d;
      ltssm_s_q     <= ltssm_s_d;
      perst_n_q     <= perst_n_d;
      npor_q        <= npor_d;
      link_up_q     <= link_up_d;
      link_fail_q   <= link_fail_d;
    end
  end

  assign perst_n     = perst_n_q;
  assign npor        = npor_q;
  assign link_up     = link_up_q;
  assign link_fail   = link_fail_q;
  assign retry_count = retry_q;
  assign seq_state   = state_q;

endmodule
